// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word request at a time, waits LATENCY cycles,
// then completes with a one-cycle ready pulse. Supports byte-lane writes and range errors.
module dm_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_enable,
    input  logic        DM_write,
    input  logic [31:0] DM_address,
    input  logic [31:0] DM_in,
    input  logic [3:0]  DM_wstrb,
    output logic [31:0] DM_out,
    output logic        ready,
    output logic        DM_err,
    output logic [1:0]  o_state
);

    // Handshake: DM_enable is held by the requester from acceptance until the
    // ready pulse; dropping it while waiting aborts the access with no ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_wr;
    logic [3:0]  r_strb;
    logic [31:0] r_dm_out;
    logic [31:0] r_mem [0:(1 << DEPTH_LOG2) - 1];

    logic [31:0]           w_acc_addr;
    logic                  w_acc_wr;
    logic                  w_acc_oob;
    logic                  w_resp_oob;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [DEPTH_LOG2-1:0] w_resp_idx;
    logic                  w_enter_resp;
    logic                  w_unused;

    // With LATENCY = 1 the read happens on the acceptance edge, so the
    // request fields come straight from the inputs while idle.
    assign w_acc_addr   = (r_state == S_IDLE) ? DM_address : r_addr;
    assign w_acc_wr     = (r_state == S_IDLE) ? DM_write : r_wr;
    assign w_acc_oob    = |w_acc_addr[31:DEPTH_LOG2+2];
    assign w_resp_oob   = |r_addr[31:DEPTH_LOG2+2];
    assign w_acc_idx    = w_acc_addr[DEPTH_LOG2+1:2];
    assign w_resp_idx   = r_addr[DEPTH_LOG2+1:2];
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_unused     = &{1'b0, w_acc_addr[1:0], r_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (DM_enable) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!DM_enable) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = 1'b0;
        DM_err  = 1'b0;
        o_state = r_state;
        if (r_state == S_RESP) begin
            ready  = 1'b1;
            DM_err = w_resp_oob;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            r_wr     <= 1'b0;
            r_strb   <= 4'd0;
            r_dm_out <= 32'd0;
        end else begin
            if (r_state == S_IDLE && DM_enable) begin
                r_addr <= DM_address;
                r_data <= DM_in;
                r_wr   <= DM_write;
                r_strb <= DM_wstrb;
                r_cnt  <= LAT_M1;
            end else if (r_state == S_WAIT && DM_enable) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && !w_acc_wr) begin
                r_dm_out <= w_acc_oob ? 32'd0 : r_mem[w_acc_idx];
            end
        end
    end

    // The write commits on the edge that leaves RESP; reset leaves the array alone.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP && r_wr && !w_resp_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) begin
                    r_mem[w_resp_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

    assign DM_out = r_dm_out;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: unit 0 runs with LATENCY = 2, unit 1 with LATENCY = 3.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        en   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [3:0]  strb [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        err  [2];
    logic [1:0]  st   [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int last_ready_cyc;
    int lat;
    logic [31:0] rd;
    logic er;

    dm_responder #(.LATENCY(2), .DEPTH_LOG2(14)) u_dut2 (
        .clk(clk), .rst(rst), .DM_enable(en[0]), .DM_write(wr[0]),
        .DM_address(addr[0]), .DM_in(din[0]), .DM_wstrb(strb[0]),
        .DM_out(dout[0]), .ready(rdy[0]), .DM_err(err[0]), .o_state(st[0])
    );

    dm_responder #(.LATENCY(3), .DEPTH_LOG2(14)) u_dut3 (
        .clk(clk), .rst(rst), .DM_enable(en[1]), .DM_write(wr[1]),
        .DM_address(addr[1]), .DM_in(din[1]), .DM_wstrb(strb[1]),
        .DM_out(dout[1]), .ready(rdy[1]), .DM_err(err[1]), .o_state(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Issues one request starting in the current (idle) cycle and returns in the
    // idle cycle after ready, so calls chain back to back.
    task automatic access(input int u, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int l, output logic [31:0] r, output logic e);
        en[u] = 1'b1; wr[u] = w; addr[u] = a; din[u] = d; strb[u] = s;
        l = -1; r = 32'd0; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (rdy[u]) begin
                l = c; r = dout[u]; e = err[u]; last_ready_cyc = cyc_cnt;
                break;
            end
        end
        en[u] = 1'b0; wr[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_tests++; if (st[u] !== 2'd0) begin n_fail++; $display("FAIL reset_state u%0d: got %0d want 0", u, st[u]); end
            n_tests++; if (rdy[u] !== 1'b0) begin n_fail++; $display("FAIL reset_ready u%0d: got %b want 0", u, rdy[u]); end
            n_tests++; if (err[u] !== 1'b0) begin n_fail++; $display("FAIL reset_err u%0d: got %b want 0", u, err[u]); end
            n_tests++; if (dout[u] !== 32'd0) begin n_fail++; $display("FAIL reset_dout u%0d: got %h want 0", u, dout[u]); end
        end
    endtask

    task automatic test_single_read();
        access(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, lat, rd, er);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL preload_latency: got %0d want 2", lat); end
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h40;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            n_tests++; if (rdy[0] !== (c == 2)) begin n_fail++; $display("FAIL read_ready_c%0d: got %b want %b", c, rdy[0], (c == 2)); end
            if (c == 2) begin
                en[0] = 1'b0;
                n_tests++; if (dout[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", dout[0]); end
                n_tests++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err[0]); end
            end
        end
        n_tests++; if (dout[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold: got %h want deadbeef", dout[0]); end
    endtask

    task automatic test_line_fill();
        int k;
        for (int i = 0; i < 4; i++) access(0, 1'b1, 32'h100 + 4*i, 32'hF1110000 + i, 4'hF, lat, rd, er);
        k = 0;
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h100;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            n_tests++; if (rdy[0] !== (c % 3 == 2 && c < 12)) begin n_fail++; $display("FAIL fill_ready_c%0d: got %b want %b", c, rdy[0], (c % 3 == 2 && c < 12)); end
            if (c % 3 == 2 && c < 12) begin
                n_tests++; if (dout[0] !== 32'hF1110000 + k) begin n_fail++; $display("FAIL fill_data_%0d: got %h want %h", k, dout[0], 32'hF1110000 + k); end
                k++;
                if (k == 4) en[0] = 1'b0;
                else addr[0] = 32'h100 + 4*k;
            end
        end
    endtask

    task automatic test_byte_write();
        access(0, 1'b1, 32'h80, 32'h11223344, 4'hF, lat, rd, er);
        access(0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0100, lat, rd, er);
        access(0, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h11BB3344) begin n_fail++; $display("FAIL byte_write: got %h want 11bb3344", rd); end
        access(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, lat, rd, er);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL zero_strb_latency: got %0d want 2", lat); end
        access(0, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h11BB3344) begin n_fail++; $display("FAIL zero_strb_data: got %h want 11bb3344", rd); end
    endtask

    task automatic test_wait_ignore();
        access(0, 1'b1, 32'h84, 32'h0, 4'hF, lat, rd, er);
        access(0, 1'b1, 32'h88, 32'h77777777, 4'hF, lat, rd, er);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h84; din[0] = 32'h00001234; strb[0] = 4'hF;
        @(posedge clk); #1;
        addr[0] = 32'h88; din[0] = 32'hFFFFFFFF; strb[0] = 4'h1;
        @(posedge clk); #1;
        n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL wait_ignore_ready: got %b want 1", rdy[0]); end
        en[0] = 1'b0; wr[0] = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b0, 32'h84, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL wait_ignore_target: got %h want 00001234", rd); end
        access(0, 1'b0, 32'h88, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h77777777) begin n_fail++; $display("FAIL wait_ignore_other: got %h want 77777777", rd); end
    endtask

    task automatic test_back_to_back();
        int first_ready;
        access(0, 1'b1, 32'h300, 32'h13579BDF, 4'hF, lat, rd, er);
        first_ready = last_ready_cyc;
        access(0, 1'b0, 32'h300, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h13579BDF) begin n_fail++; $display("FAIL b2b_data: got %h want 13579bdf", rd); end
        n_tests++; if (last_ready_cyc - first_ready !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", last_ready_cyc - first_ready); end
    endtask

    task automatic test_out_of_range();
        access(0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, lat, rd, er);
        access(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL oob_latency: got %0d want 2", lat); end
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_read_err: got %b want 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oob_read_data: got %h want 0", rd); end
        access(0, 1'b1, 32'h0001_0000, 32'h12345678, 4'hF, lat, rd, er);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_write_err: got %b want 1", er); end
        access(0, 1'b1, 32'h8000_0040, 32'h12345678, 4'hF, lat, rd, er);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'hCAFE0000) begin n_fail++; $display("FAIL oob_alias0: got %h want cafe0000", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL inrange_err: got %b want 0", er); end
        access(0, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oob_alias40: got %h want deadbeef", rd); end
    endtask

    task automatic test_abort();
        access(1, 1'b1, 32'h200, 32'h55AA55AA, 4'hF, lat, rd, er);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_latency: got %0d want 3", lat); end
        access(1, 1'b0, 32'h200, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL lat3_read: got %h want 55aa55aa", rd); end
        en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h200; din[1] = 32'h0; strb[1] = 4'hF;
        @(posedge clk); #1;
        n_tests++; if (st[1] !== 2'd1) begin n_fail++; $display("FAIL abort_wait_state: got %0d want 1", st[1]); end
        en[1] = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (st[1] !== 2'd0) begin n_fail++; $display("FAIL abort_idle_state: got %0d want 0", st[1]); end
        n_tests++; if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", rdy[1]); end
        n_tests++; if (dout[1] !== 32'h55AA55AA) begin n_fail++; $display("FAIL abort_dout: got %h want 55aa55aa", dout[1]); end
        en[1] = 1'b1; wr[1] = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            @(posedge clk); #1;
            n_tests++; if (rdy[1] !== (c == 5)) begin n_fail++; $display("FAIL abort_next_ready_c%0d: got %b want %b", c, rdy[1], (c == 5)); end
        end
        en[1] = 1'b0;
        n_tests++; if (dout[1] !== 32'h55AA55AA) begin n_fail++; $display("FAIL abort_array: got %h want 55aa55aa", dout[1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h200; din[1] = 32'h01020304; strb[1] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++; if (st[1] !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d want 0", st[1]); end
        n_tests++; if (dout[1] !== 32'd0) begin n_fail++; $display("FAIL rst_mid_dout: got %h want 0", dout[1]); end
        en[1] = 1'b0; wr[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rdy[1]) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", seen); end
        access(1, 1'b0, 32'h200, 32'h0, 4'h0, lat, rd, er);
        n_tests++; if (rd !== 32'h55AA55AA) begin n_fail++; $display("FAIL rst_mid_array: got %h want 55aa55aa", rd); end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            en[u] = 1'b0; wr[u] = 1'b0; addr[u] = 32'd0; din[u] = 32'd0; strb[u] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_single_read();
        test_line_fill();
        test_byte_write();
        test_wait_ignore();
        test_back_to_back();
        test_out_of_range();
        test_abort();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
